// File: rtl/unet_stream_feeder.sv
// rtl/unet_stream_feeder.sv - host-side word feeder and result collector around unet_fsm_3_1
//
// Purpose: buffers an inbound 32-bit stream into weight and data FIFOs. It pulses
// unet_enpulse once a full run's worth of words is held. It serves those words on
// acc_data_in as the accelerator's ctrl phase requests them. It collects acc_data_out
// into a result FIFO that drains through a first-word-fall-through valid/ready stream.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   start                        host run request, level, sampled in IDLE
//   s_valid/s_ready/s_is_weight/s_data   inbound word stream, routed by s_is_weight
//   unet_enpulse                 one-cycle accelerator start pulse
//   ctrl, busy                   accelerator phase and busy flag
//   acc_data_in, acc_data_out    words to / results from the accelerator
//   m_valid/m_ready/m_data       outbound result stream
//   run_done                     one-cycle pulse on the RUN -> IDLE transition
//   err_underrun, err_overflow   sticky error flags, cleared by err_clr
//   perf_cycles                  RUN cycle counter (only with UNET_FEED_PERF_EN)
//
// Optional feature macro: UNET_FEED_PERF_EN

module unet_feed_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  // Reads as zero when empty, so that no unwritten storage reaches an output.
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

module unet_stream_feeder #(
  parameter int FIFO_DEPTH = 64,
  parameter int WGT_WORDS  = 9,
  parameter int DATA_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_is_weight,
  input  logic [31:0] s_data,
  output logic        unet_enpulse,
  input  logic [2:0]  ctrl,
  input  logic        busy,
  output logic [31:0] acc_data_in,
  input  logic [31:0] acc_data_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        run_done,
  output logic        err_underrun,
  output logic        err_overflow,
  input  logic        err_clr
`ifdef UNET_FEED_PERF_EN
  ,output logic [31:0] perf_cycles
`endif
);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int WSW = $clog2(WGT_WORDS+1);
  localparam int DSW = $clog2(DATA_WORDS+1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_PULSE, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [WSW-1:0] wsent;
  logic [DSW-1:0] dsent;
  logic           seen_busy;
  logic           exit_run;

  logic [31:0]    w_head, d_head, r_head;
  logic           wfull, wempty, dfull, dempty, rfull, rempty;
  logic [CW-1:0]  wcount, dcount, rcount;

  logic in_run, req_w, req_d, cap;
  logic w_avail, d_avail, w_pop, d_pop, w_push, d_push, r_push, r_pop, drop;

  assign in_run  = (state == ST_RUN);
  assign req_w   = in_run && (ctrl == 3'd1);
  assign req_d   = in_run && (ctrl == 3'd2);
  assign cap     = in_run && (ctrl == 3'd3);
  assign w_avail = (wsent < WSW'(WGT_WORDS));
  assign d_avail = (dsent < DSW'(DATA_WORDS));
  assign w_pop   = req_w && w_avail;
  assign d_pop   = req_d && d_avail;

  assign s_ready = s_is_weight ? !wfull : !dfull;
  assign w_push  = s_valid && s_is_weight && !wfull;
  assign d_push  = s_valid && !s_is_weight && !dfull;

  // A full result FIFO still accepts a capture when the head leaves the same cycle.
  assign r_pop   = !rempty && m_ready;
  assign r_push  = cap && (!rfull || m_ready);
  assign drop    = cap && rfull && !m_ready;

  assign m_valid = !rempty;
  assign m_data  = r_head;

  unet_feed_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_wfifo (
    .clk(clk), .rst_n(rst_n), .push(w_push), .push_data(s_data), .pop(w_pop),
    .head(w_head), .full(wfull), .empty(wempty), .count(wcount)
  );

  unet_feed_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_dfifo (
    .clk(clk), .rst_n(rst_n), .push(d_push), .push_data(s_data), .pop(d_pop),
    .head(d_head), .full(dfull), .empty(dempty), .count(dcount)
  );

  unet_feed_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rfifo (
    .clk(clk), .rst_n(rst_n), .push(r_push), .push_data(acc_data_out), .pop(r_pop),
    .head(r_head), .full(rfull), .empty(rempty), .count(rcount)
  );

  always_comb begin
    state_nxt    = state;
    unet_enpulse = 1'b0;
    exit_run     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ARM;
      ST_ARM:   if (wcount >= CW'(WGT_WORDS) && dcount >= CW'(DATA_WORDS)) state_nxt = ST_PULSE;
      ST_PULSE: begin
        unet_enpulse = 1'b1;
        state_nxt    = ST_RUN;
      end
      ST_RUN: begin
        // seen_busy keeps a not-yet-started accelerator's idle ctrl from ending the run.
        if (seen_busy && !busy && ctrl == 3'd4) begin
          exit_run  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign run_done = exit_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wsent        <= '0;
      dsent        <= '0;
      seen_busy    <= 1'b0;
      acc_data_in  <= '0;
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_PULSE) begin
        wsent     <= '0;
        dsent     <= '0;
        seen_busy <= 1'b0;
      end
      if (in_run && busy) seen_busy <= 1'b1;

      if (req_w) begin
        acc_data_in <= w_avail ? w_head : '0;
        if (w_avail) wsent <= wsent + WSW'(1);
      end else if (req_d) begin
        acc_data_in <= d_avail ? d_head : '0;
        if (d_avail) dsent <= dsent + DSW'(1);
      end

      if (err_clr)                                          err_underrun <= 1'b0;
      else if ((req_w && !w_avail) || (req_d && !d_avail))  err_underrun <= 1'b1;

      if (err_clr)   err_overflow <= 1'b0;
      else if (drop) err_overflow <= 1'b1;
    end
  end

`ifdef UNET_FEED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  perf_cycles <= '0;
    else if (state == ST_PULSE)                  perf_cycles <= '0;
    else if (in_run && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_unet_stream_feeder.sv
// tb/tb_unet_stream_feeder.sv - self-checking bench for unet_stream_feeder
module tb_unet_stream_feeder;
  localparam int DEPTH = 64;
  localparam int NW    = 9;
  localparam int ND    = 16;

  logic        clk, rst_n, start, s_valid, s_ready, s_is_weight;
  logic [31:0] s_data, acc_data_in, acc_data_out, m_data;
  logic        unet_enpulse, busy, m_valid, m_ready, run_done;
  logic        err_underrun, err_overflow, err_clr;
  logic [2:0]  ctrl;
`ifdef UNET_FEED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  unet_stream_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_is_weight(s_is_weight), .s_data(s_data), .unet_enpulse(unet_enpulse),
    .ctrl(ctrl), .busy(busy), .acc_data_in(acc_data_in), .acc_data_out(acc_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .run_done(run_done),
    .err_underrun(err_underrun), .err_overflow(err_overflow), .err_clr(err_clr)
`ifdef UNET_FEED_PERF_EN
    ,.perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues stand in for the FIFOs, the run is tracked by phase name.
  typedef enum int {M_IDLE, M_ARM, M_PULSE, M_RUN} mphase_t;
  mphase_t     phase;
  logic [31:0] wq[$], dq[$], rq[$];
  int          wsent_m, dsent_m, wn, dn, rn;
  bit          seen_m, und_m, ovf_m, und_set, ovf_set, capture;
  logic [31:0] acc_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq.delete(); dq.delete(); rq.delete();
      phase = M_IDLE; wsent_m = 0; dsent_m = 0; seen_m = 0;
      und_m = 0; ovf_m = 0; acc_m = 0;
    end else begin
      wn = wq.size(); dn = dq.size(); rn = rq.size();
      und_set = 0; ovf_set = 0; capture = 0;
      case (phase)
        M_IDLE:  if (start) phase = M_ARM;
        M_ARM:   if (wn >= NW && dn >= ND) phase = M_PULSE;
        M_PULSE: begin wsent_m = 0; dsent_m = 0; seen_m = 0; phase = M_RUN; end
        M_RUN: begin
          if (ctrl == 3'd1) begin
            if (wsent_m < NW) begin acc_m = (wn > 0) ? wq.pop_front() : 32'd0; wsent_m++; end
            else begin acc_m = 0; und_set = 1; end
          end else if (ctrl == 3'd2) begin
            if (dsent_m < ND) begin acc_m = (dn > 0) ? dq.pop_front() : 32'd0; dsent_m++; end
            else begin acc_m = 0; und_set = 1; end
          end else if (ctrl == 3'd3) begin
            if (rn < DEPTH || m_ready) capture = 1; else ovf_set = 1;
          end
          if (seen_m && !busy && ctrl == 3'd4) phase = M_IDLE;
          if (busy) seen_m = 1;
        end
        default: phase = M_IDLE;
      endcase
      if (rn > 0 && m_ready) void'(rq.pop_front());
      if (capture) rq.push_back(acc_data_out);
      if (s_valid && s_is_weight && wn < DEPTH) wq.push_back(s_data);
      if (s_valid && !s_is_weight && dn < DEPTH) dq.push_back(s_data);
      if (err_clr) begin und_m = 0; ovf_m = 0; end
      else begin
        if (und_set) und_m = 1;
        if (ovf_set) ovf_m = 1;
      end
    end
  end

  logic [31:0] exp_md;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_md = 32'd0;
        if (rq.size() > 0) exp_md = rq[0];
        chk("acc_data_in", acc_data_in, acc_m);
        chk("m_valid", 32'(m_valid), 32'(rq.size() > 0));
        chk("m_data", m_data, exp_md);
        chk("unet_enpulse", 32'(unet_enpulse), 32'(phase == M_PULSE));
        chk("run_done", 32'(run_done), 32'(phase == M_RUN && seen_m && !busy && ctrl == 3'd4));
        chk("err_underrun", 32'(err_underrun), 32'(und_m));
        chk("err_overflow", 32'(err_overflow), 32'(ovf_m));
        chk("s_ready", 32'(s_ready), 32'(s_is_weight ? (wq.size() < DEPTH) : (dq.size() < DEPTH)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wv(input int i); return 32'h1000_0000 + 32'(i); endfunction
  function automatic logic [31:0] dv(input int i); return 32'h2000_0000 + 32'(i); endfunction

  int pulses;
  bit got;

  initial begin
    start = 0; s_valid = 0; s_is_weight = 0; s_data = 0; ctrl = 0; busy = 0;
    acc_data_out = 0; m_ready = 0; err_clr = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    chk("rst_acc", acc_data_in, 0);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_enpulse", 32'(unet_enpulse), 0);
    chk("rst_done", 32'(run_done), 0);
    chk("rst_errs", {30'd0, err_underrun, err_overflow}, 0);
    chk("rst_sready", 32'(s_ready), 1);

    // Arm with one data word short, then complete
    start = 1; tick(); start = 0;
    s_valid = 1; s_is_weight = 1;
    for (int i = 0; i < NW; i++) begin s_data = wv(i); tick(); end
    s_is_weight = 0;
    for (int i = 0; i < ND - 1; i++) begin s_data = dv(i); tick(); end
    s_valid = 0;
    repeat (4) begin tick(); chk("arm_no_pulse", 32'(unet_enpulse), 0); end
    s_valid = 1; s_data = dv(ND - 1); tick(); s_valid = 0;
    pulses = 0;
    repeat (6) begin tick(); pulses += int'(unet_enpulse); end
    chk("pulse_count", pulses, 1);

    // Weights served one per cycle
    busy = 1; tick();
    ctrl = 3'd1;
    for (int k = 0; k < NW; k++) begin tick(); chk("acc_weight", acc_data_in, wv(k)); end
    // Underrun on the tenth request
    tick();
    chk("underrun_acc", acc_data_in, 0);
    chk("underrun_flag", 32'(err_underrun), 1);
    ctrl = 0; err_clr = 1; tick(); err_clr = 0;
    chk("underrun_clr", 32'(err_underrun), 0);
    ctrl = 3'd1; err_clr = 1; tick(); ctrl = 0; err_clr = 0;
    chk("clr_priority_und", 32'(err_underrun), 0);

    // Data served, then held under CALC
    ctrl = 3'd2;
    for (int k = 0; k < ND; k++) begin tick(); chk("acc_data", acc_data_in, dv(k)); end
    ctrl = 3'd0; tick();
    chk("acc_hold", acc_data_in, dv(ND - 1));
    ctrl = 3'd6; tick(); ctrl = 0;
    chk("acc_hold_invalid", acc_data_in, dv(ND - 1));

    // Result capture and in-order drain
    m_ready = 0; ctrl = 3'd3;
    for (int i = 0; i < 4; i++) begin acc_data_out = 32'hA0 + 32'(i); tick(); end
    ctrl = 0;
    chk("res_valid", 32'(m_valid), 1);
    chk("res_head", m_data, 32'hA0);
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin chk("res_order", m_data, 32'hA0 + 32'(i)); tick(); end
    chk("res_empty", 32'(m_valid), 0);
    m_ready = 0;

    // Overflow: 66 captures into a 64-deep FIFO
    ctrl = 3'd3;
    for (int i = 0; i < DEPTH + 2; i++) begin acc_data_out = 32'hB00 + 32'(i); tick(); end
    ctrl = 0;
    chk("ovf_flag", 32'(err_overflow), 1);
    chk("ovf_head", m_data, 32'hB00);
    err_clr = 1; tick(); err_clr = 0;
    chk("ovf_clr", 32'(err_overflow), 0);
    ctrl = 3'd3; err_clr = 1; acc_data_out = 32'hDEAD; tick(); ctrl = 0; err_clr = 0;
    chk("clr_priority_ovf", 32'(err_overflow), 0);
    ctrl = 3'd3; m_ready = 1; acc_data_out = 32'hC00; tick(); ctrl = 0; m_ready = 0;
    chk("full_push_pop", 32'(err_overflow), 0);
    chk("full_push_pop_head", m_data, 32'hB01);
    m_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_drain", m_data, (i < DEPTH - 1) ? 32'hB01 + 32'(i) : 32'hC00);
      tick();
    end
    chk("ovf_drained", 32'(m_valid), 0);
    m_ready = 0;

    // Run completion
    busy = 0; ctrl = 3'd4; #2;
    chk("run_done_hi", 32'(run_done), 1);
    tick(); ctrl = 0;
    chk("run_done_lo", 32'(run_done), 0);

    // Second run aborted by reset during SEND_DATA
    s_valid = 1; s_is_weight = 1;
    for (int i = 0; i < NW; i++) begin s_data = wv(i + 32); tick(); end
    s_is_weight = 0;
    for (int i = 0; i < ND; i++) begin s_data = dv(i + 32); tick(); end
    s_valid = 0;
    start = 1; tick(); start = 0;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin tick(); if (unet_enpulse) got = 1; end
    chk("second_pulse", 32'(got), 1);
    busy = 1; tick();
    ctrl = 3'd3; acc_data_out = 32'hE0; tick(); tick();
    ctrl = 3'd2; tick(); tick(); tick();
    chk("pre_rst_acc", acc_data_in, dv(34));
    chk("pre_rst_mvalid", 32'(m_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_acc", acc_data_in, 0);
    chk("arst_mvalid", 32'(m_valid), 0);
    chk("arst_enpulse", 32'(unet_enpulse), 0);
    chk("arst_sready", 32'(s_ready), 1);
    chk("arst_errs", {30'd0, err_underrun, err_overflow}, 0);
`ifdef UNET_FEED_PERF_EN
    chk("arst_perf", perf_cycles, 0);
`endif
    ctrl = 0; busy = 0;
    tick(); rst_n = 1;
    tick(); tick();
    chk("post_rst_mvalid", 32'(m_valid), 0);
    chk("post_rst_enpulse", 32'(unet_enpulse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
